// File: rtl/snapshot_pkg.sv
// rtl/snapshot_pkg.sv - shared types and helpers for the snapshot register protocol
//
// Holds the master FSM state enum, the partition-count helper (also used by
// the responder) and the byte width constant. No ports.
package snapshot_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } snap_mst_state_e;

  // Number of DATA_WIDTH beats needed to cover a reg_w-bit register.
  function automatic int part_cnt(input int reg_w, input int data_w);
    return (reg_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/snapshot_perf_cnt.sv
// rtl/snapshot_perf_cnt.sv - saturating 16-bit event counter
//
// Present only when SNAPSHOT_MASTER_PERF_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (wins over inc)
//   inc         count one event
//   cnt         current count, sticks at 16'hFFFF
`ifdef SNAPSHOT_MASTER_PERF_EN
module snapshot_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/snapshot_master.sv
// rtl/snapshot_master.sv - initiator for the partitioned snapshot register protocol
//
// Splits one wide register read/write into PARTITION_CNT beats on snap_*.
// Writes go high partition to low (partition 0 commits), reads go low to
// high (partition 0 snapshots). One response per request.
// Optional feature macro: SNAPSHOT_MASTER_PERF_EN adds perf_wr_cnt/perf_rd_cnt.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mst__fsm__sync_reset    synchronous abort, shared with the responder
//   req_vld/req_rdy         request handshake; req_wr, req_wdata payload
//   rsp_vld/rsp_rdy         response handshake; rsp_rdata payload
//   snap_wr_en/snap_rd_en   one-hot beat strobes
//   snap_wr_data            beat data in its partition slot
//   snap_rd_data            responder read data (combinational)
//   perf_wr_cnt/perf_rd_cnt saturating handshake counters (macro only)
module snapshot_master
  import snapshot_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_WIDTH     = 36,
  parameter int PARTITION_CNT = part_cnt(REG_WIDTH, DATA_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mst__fsm__sync_reset,
  input  logic                                req_vld,
  output logic                                req_rdy,
  input  logic                                req_wr,
  input  logic [REG_WIDTH-1:0]                req_wdata,
  output logic                                rsp_vld,
  input  logic                                rsp_rdy,
  output logic [REG_WIDTH-1:0]                rsp_rdata,
  output logic [PARTITION_CNT-1:0]            snap_wr_en,
  output logic [PARTITION_CNT-1:0]            snap_rd_en,
  output logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_wr_data,
  input  logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_rd_data
`ifdef SNAPSHOT_MASTER_PERF_EN
  ,
  output logic [15:0]                         perf_wr_cnt,
  output logic [15:0]                         perf_rd_cnt
`endif
);

  localparam int BEAT_W = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1;
  localparam int FULL_W = DATA_WIDTH * PARTITION_CNT;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PARTITION_CNT - 1);

  snap_mst_state_e        state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]   acc_q, acc_d;
  logic                   req_rdy_q, req_rdy_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic [REG_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [PARTITION_CNT-1:0] snap_wr_en_q, snap_wr_en_d;
  logic [PARTITION_CNT-1:0] snap_rd_en_q, snap_rd_en_d;
  logic [FULL_W-1:0]      snap_wr_data_q, snap_wr_data_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          wdata_d = req_wdata;
          acc_d   = '0;
          if (req_wr) begin
            state_d = WR;
            beat_d  = LAST_BEAT;
          end else begin
            state_d = RD;
            beat_d  = '0;
          end
        end
      end
      WR: begin
        if (beat_q == '0) state_d = RSP;
        else              beat_d  = beat_q - BEAT_W'(1);
      end
      RD: begin
        // Read data is valid in the same cycle as the strobe.
        for (int j = 0; j < REG_WIDTH; j++) begin
          if (j / DATA_WIDTH == int'(beat_q)) acc_d[j] = snap_rd_data[j];
        end
        if (beat_q == LAST_BEAT) state_d = RSP;
        else                     beat_d  = beat_q + BEAT_W'(1);
      end
      RSP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mst__fsm__sync_reset) begin
      state_d = IDLE;
      beat_d  = '0;
      wdata_d = '0;
      acc_d   = '0;
    end

    // Outputs are registered: derive them from the next state.
    req_rdy_d      = (state_d == IDLE);
    rsp_vld_d      = (state_d == RSP);
    rsp_rdata_d    = (state_d == RSP) ? acc_d : '0;
    snap_wr_en_d   = '0;
    snap_rd_en_d   = '0;
    snap_wr_data_d = '0;
    if (state_d == WR) begin
      snap_wr_en_d[beat_d] = 1'b1;
      for (int j = 0; j < REG_WIDTH; j++) begin
        if (j / DATA_WIDTH == int'(beat_d)) snap_wr_data_d[j] = wdata_d[j];
      end
    end
    if (state_d == RD) snap_rd_en_d[beat_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      wdata_q        <= '0;
      acc_q          <= '0;
      req_rdy_q      <= 1'b1;
      rsp_vld_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      snap_wr_en_q   <= '0;
      snap_rd_en_q   <= '0;
      snap_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      wdata_q        <= wdata_d;
      acc_q          <= acc_d;
      req_rdy_q      <= req_rdy_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_rdata_q    <= rsp_rdata_d;
      snap_wr_en_q   <= snap_wr_en_d;
      snap_rd_en_q   <= snap_rd_en_d;
      snap_wr_data_q <= snap_wr_data_d;
    end
  end

  assign req_rdy      = req_rdy_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign snap_wr_en   = snap_wr_en_q;
  assign snap_rd_en   = snap_rd_en_q;
  assign snap_wr_data = snap_wr_data_q;

  // Pad bits above REG_WIDTH in the top read slot carry nothing.
  if (FULL_W > REG_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^snap_rd_data[FULL_W-1:REG_WIDTH];
  end

`ifdef SNAPSHOT_MASTER_PERF_EN
  logic wr_q, wr_d;
  logic rsp_fire;

  always_comb begin
    wr_d = wr_q;
    if (state_q == IDLE && req_vld) wr_d = req_wr;
    if (mst__fsm__sync_reset)       wr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_q <= 1'b0;
    else        wr_q <= wr_d;
  end

  assign rsp_fire = rsp_vld_q & rsp_rdy;

  snapshot_perf_cnt u_perf_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mst__fsm__sync_reset),
    .inc   (rsp_fire & wr_q),
    .cnt   (perf_wr_cnt)
  );

  snapshot_perf_cnt u_perf_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mst__fsm__sync_reset),
    .inc   (rsp_fire & ~wr_q),
    .cnt   (perf_rd_cnt)
  );
`endif

endmodule

// File: doc/snapshot_master.md
# snapshot_master

Initiator side of the partitioned snapshot register protocol. Accepts one wide register read or write request from the control FSM and sequences it into per-partition beats of DATA_WIDTH bits on the snap_* bus. It assembles the wide read result and returns a single response. The block sits between the master FSM and one snapshot register responder, and shares `mst__fsm__sync_reset` with that responder.

## Interface
- DATA_WIDTH, 32, bus beat width
- REG_WIDTH, 36, target register width (>= 1)
- PARTITION_CNT, ceil(REG_WIDTH/DATA_WIDTH), number of beats per access

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mst__fsm__sync_reset  in  1  synchronous abort
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_wdata  in  REG_WIDTH  write data
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_rdata  out  REG_WIDTH  read result (zero for writes)
- snap_wr_en  out  PARTITION_CNT  one-hot write beat strobe
- snap_rd_en  out  PARTITION_CNT  one-hot read beat strobe
- snap_wr_data  out  DATA_WIDTH*PARTITION_CNT  beat data, placed in its partition slot, zero elsewhere
- snap_rd_data  in  DATA_WIDTH*PARTITION_CNT  responder read data, combinational

## Operation
- States: IDLE, WR, RD, RSP.
- IDLE:
  - req_rdy = 1.
  - On req_vld, latch req_wr and req_wdata, clear the rdata accumulator, and go to WR or RD.
- WR:
  - Beats go high to low: partition PARTITION_CNT-1 down to 0.
  - Beat i asserts snap_wr_en[i] only, and drives req_wdata[i*DATA_WIDTH +: w] into slot i.
  - The top slot width w is REG_WIDTH - (PARTITION_CNT-1)*DATA_WIDTH. Pad bits are 0.
  - Partition 0 goes last because it commits the full register.
  - After beat 0, go to RSP.
- RD:
  - Beats go low to high: partition 0 first, because it snapshots the register.
  - Beat i asserts snap_rd_en[i] only.
  - On that cycle, capture snap_rd_data[i*DATA_WIDTH +: DATA_WIDTH] into accumulator slot i.
  - After beat PARTITION_CNT-1, go to RSP.
- RSP:
  - rsp_vld = 1 and rsp_rdata = accumulator[REG_WIDTH-1:0]. Both are held stable until rsp_rdy.
  - On rsp_rdy, go to IDLE.
- snap_wr_en and snap_rd_en are never both non-zero, and each is at most one-hot.
- snap_* outputs are zero outside WR/RD.
- The beat index is a counter of width max(1, clog2(PARTITION_CNT)). It never wraps past PARTITION_CNT-1 or below 0.
- PARTITION_CNT = 1: exactly one beat, either snap_wr_en=1'b1 or snap_rd_en=1'b1.

## Timing
- Reset (rst_n low, asynchronous) values:
  - state IDLE, req_rdy=1, rsp_vld=0, rsp_rdata=0.
  - snap_wr_en=0, snap_rd_en=0, snap_wr_data=0, beat counter 0.
- Request accepted at edge T:
  - Beats on cycles T+1 .. T+PARTITION_CNT, back to back, no gaps.
  - rsp_vld rises at T+PARTITION_CNT+1.
  - Zero-wait round trip is PARTITION_CNT+2 cycles.
- req_rdy is low from the cycle after acceptance until the cycle after the rsp handshake. There is no request overlap.
- rsp_vld with rsp_rdy in the same cycle completes the transaction. req_rdy returns at the next cycle.
- mst__fsm__sync_reset:
  - Takes priority over everything.
  - In any state, the next edge forces the reset values above.
  - An in-flight transaction is dropped with no response.
  - Beats already issued are not retracted.
- A request arriving while sync reset is high is not accepted.

## Configuration
- SNAPSHOT_MASTER_PERF_EN defined:
  - Adds outputs perf_wr_cnt[15:0] and perf_rd_cnt[15:0].
  - Each increments on its own rsp handshake and saturates at 16'hFFFF.
  - Both clear on rst_n or mst__fsm__sync_reset.
- Undefined: the ports and counters are absent, and the block behaves identically otherwise.

## Structure
- Shared package snapshot_pkg holds:
  - the state enum snap_mst_state_e (IDLE/WR/RD/RSP);
  - a partition-count function part_cnt(reg_w, data_w);
  - BYTE_WIDTH = 8.
  - The responder reuses part_cnt.
- Sub-module snapshot_perf_cnt (one saturating 16-bit counter, instantiated twice) exists only under SNAPSHOT_MASTER_PERF_EN.
- The FSM, beat counter and accumulator stay inline.

## Test plan
All scenarios use DATA_WIDTH=32, REG_WIDTH=36, PARTITION_CNT=2 unless stated.
- Write 36'hA_1234_5678:
  - Beat 1 drives snap_wr_en=2'b10 with snap_wr_data[63:32]=32'h0000_000A.
  - Beat 2 drives snap_wr_en=2'b01 with snap_wr_data[31:0]=32'h1234_5678.
  - rsp_vld follows at T+3; the paired responder commits 36'hA12345678.
- Read with the responder holding 36'h5_DEAD_BEEF:
  - Beats drive snap_rd_en=2'b01 then 2'b10.
  - rsp_rdata=36'h5DEADBEEF.
- Backpressure: hold rsp_rdy=0 for 5 cycles.
  - rsp_vld and rsp_rdata stay stable.
  - req_rdy stays 0 and a second req_vld is ignored until the handshake.
- Assert mst__fsm__sync_reset during a read's second beat:
  - Next cycle is IDLE, req_rdy=1, snap_rd_en=0.
  - No rsp_vld is ever produced.
- With REG_WIDTH=DATA_WIDTH=32, write 32'hCAFE_F00D:
  - A single beat, snap_wr_en=1'b1.
  - rsp_vld at T+2.
- With PERF_EN: 3 writes and 2 reads give perf_wr_cnt=3 and perf_rd_cnt=2.
  - Forcing the counter to 16'hFFFF, then one more write, leaves it at 16'hFFFF.
